// File: rtl/trace_request_queue.sv
// Time-ordered request queue for trace replay: entries wait in a circular
// buffer until the simulation time counter reaches their issue time.
module trace_request_queue #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIME_W  = 33,
  parameter int unsigned OP_W    = 2,
  parameter int unsigned ADDR_W  = 33,
  parameter int unsigned SKIP_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TIME_W-1:0]          in_time,
  input  logic [OP_W-1:0]            in_op,
  input  logic [ADDR_W-1:0]          in_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TIME_W-1:0]          out_time,
  output logic [OP_W-1:0]            out_op,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [TIME_W-1:0]          cur_time,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [1:0]                 state,
  output logic                       order_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  logic [TIME_W-1:0] mem_time [DEPTH];
  logic [OP_W-1:0]   mem_op   [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [TIME_W-1:0] time_q;
  logic [TIME_W-1:0] last_time;
  logic              err_q;
  logic              enq;
  logic              deq;
  logic              skip;
  state_t            st;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_W'(DEPTH));
  assign in_ready  = !full;
  assign count     = cnt;
  assign cur_time  = time_q;
  assign order_err = err_q;

  assign out_time  = mem_time[rd_ptr];
  assign out_op    = mem_op[rd_ptr];
  assign out_addr  = mem_addr[rd_ptr];
  assign out_valid = !empty && (out_time <= time_q);

  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  // Compared one bit wider so cur_time+1 cannot wrap at all-ones.
  assign skip = (SKIP_EN != 0) && empty && enq &&
                ({1'b0, in_time} > ({1'b0, time_q} + (TIME_W + 1)'(1)));

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_time[wr_ptr] <= in_time;
      mem_op[wr_ptr]   <= in_op;
      mem_addr[wr_ptr] <= in_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      time_q    <= '0;
      last_time <= '0;
      err_q     <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr    <= wr_ptr + PTR_W'(1);
        last_time <= in_time;
        if (in_time < last_time) err_q <= 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (skip)                time_q <= in_time;
      else if (time_q != '1)   time_q <= time_q + TIME_W'(1);
    end
  end

  always_comb begin
    st = IDLE;
    if (out_valid)   st = ISSUE;
    else if (!empty) st = WAIT;
  end

  assign state = st;

endmodule

// File: tb/tb_trace_request_queue.sv
// Directed bench for trace_request_queue: one instance with time-skip, one without.
module tb_trace_request_queue;

  logic clk = 1'b0;
  logic rst;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [32:0] s_in_time, s_in_addr, s_out_time, s_out_addr, s_cur_time;
  logic [1:0]  s_in_op, s_out_op, s_state;
  logic [2:0]  s_count;
  logic        s_full, s_empty, s_order_err;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [32:0] n_in_time, n_in_addr, n_out_time, n_out_addr, n_cur_time;
  logic [1:0]  n_in_op, n_out_op, n_state;
  logic [2:0]  n_count;
  logic        n_full, n_empty, n_order_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trace_request_queue #(.DEPTH(4), .SKIP_EN(1)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_time(s_in_time), .in_op(s_in_op), .in_addr(s_in_addr),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_time(s_out_time), .out_op(s_out_op), .out_addr(s_out_addr),
    .cur_time(s_cur_time), .count(s_count), .full(s_full), .empty(s_empty),
    .state(s_state), .order_err(s_order_err)
  );

  trace_request_queue #(.DEPTH(4), .SKIP_EN(0)) dut_n (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_time(n_in_time), .in_op(n_in_op), .in_addr(n_in_addr),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_time(n_out_time), .out_op(n_out_op), .out_addr(n_out_addr),
    .cur_time(n_cur_time), .count(n_count), .full(n_full), .empty(n_empty),
    .state(n_state), .order_err(n_order_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_in_valid = 0; s_in_time = '0; s_in_op = '0; s_in_addr = '0; s_out_ready = 0;
    n_in_valid = 0; n_in_time = '0; n_in_op = '0; n_in_addr = '0; n_out_ready = 0;

    // Reset state
    #3;
    chk("rst_count", s_count, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_in_ready", s_in_ready, 1);
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_state", s_state, 0);
    chk("rst_cur_time", s_cur_time, 0);
    chk("rst_order_err", s_order_err, 0);
    step();
    chk("rst_hold_cur_time", s_cur_time, 0);
    rst = 1'b0;
    step();
    chk("first_edge_cur_s", s_cur_time, 1);
    chk("first_edge_cur_n", n_cur_time, 1);

    // Gating without skip: entry due at 5 enqueued at cur_time 1
    n_in_valid = 1; n_in_time = 33'd5; n_in_op = 2'd2; n_in_addr = 33'h55;
    step();
    n_in_valid = 0;
    chk("gate_cur2", n_cur_time, 2);
    chk("gate_count", n_count, 1);
    chk("gate_ov_t2", n_out_valid, 0);
    chk("gate_state_t2", n_state, 1);
    step();
    chk("gate_ov_t3", n_out_valid, 0);
    step();
    chk("gate_cur4", n_cur_time, 4);
    chk("gate_ov_t4", n_out_valid, 0);
    chk("gate_state_t4", n_state, 1);
    step();
    chk("gate_cur5", n_cur_time, 5);
    chk("gate_ov_t5", n_out_valid, 1);
    chk("gate_state_t5", n_state, 2);
    chk("gate_addr", n_out_addr, 33'h55);
    n_out_ready = 1;
    step();
    n_out_ready = 0;
    chk("gate_drained", n_count, 0);
    chk("gate_empty", n_empty, 1);

    // Skip: empty queue jumps straight to a far-future entry
    chk("skip_pre_cur", s_cur_time, 6);
    s_in_valid = 1; s_in_time = 33'd50; s_in_op = 2'd1; s_in_addr = 33'h1A0;
    step();
    s_in_valid = 0;
    chk("skip_cur", s_cur_time, 50);
    chk("skip_ov", s_out_valid, 1);
    chk("skip_state", s_state, 2);
    chk("skip_addr", s_out_addr, 33'h1A0);
    chk("skip_op", s_out_op, 1);
    s_out_ready = 1;
    step();
    s_out_ready = 0;
    chk("skip_drain_count", s_count, 0);
    chk("skip_drain_cur", s_cur_time, 51);
    chk("skip_drain_state", s_state, 0);

    rst = 1'b1; #2; rst = 1'b0;
    chk("pulse_cur", s_cur_time, 0);

    // Full and wrap
    s_in_valid = 1; s_in_op = 2'd3;
    for (int i = 0; i < 4; i++) begin
      s_in_time = 33'(10 + i); s_in_addr = 33'(32'h100 + i);
      step();
    end
    chk("full_count", s_count, 4);
    chk("full_flag", s_full, 1);
    chk("full_in_ready", s_in_ready, 0);
    chk("full_cur", s_cur_time, 13);
    s_in_time = 33'd99;
    step();
    chk("full_reject_count", s_count, 4);
    chk("full_head", s_out_time, 10);
    s_out_ready = 1;
    chk("full_ov", s_out_valid, 1);
    step();
    chk("full_deq_no_enq", s_count, 3);
    chk("full_deq_head", s_out_time, 11);
    s_in_time = 33'd14;
    step();
    chk("wrap_count_a", s_count, 3);
    chk("wrap_head_a", s_out_time, 12);
    s_in_time = 33'd15;
    step();
    chk("wrap_count_b", s_count, 3);
    chk("wrap_head_b", s_out_time, 13);
    s_in_valid = 0;
    step();
    chk("wrap_head_c", s_out_time, 14);
    chk("wrap_count_c", s_count, 2);
    step();
    chk("wrap_head_d", s_out_time, 15);
    chk("wrap_ov_d", s_out_valid, 1);
    step();
    chk("wrap_empty", s_empty, 1);
    chk("wrap_cur", s_cur_time, 20);
    s_out_ready = 0;

    // Simultaneous enqueue and dequeue at count 2
    s_in_valid = 1; s_in_time = 33'd30;
    step();
    s_in_time = 33'd31;
    step();
    chk("sim_count_pre", s_count, 2);
    chk("sim_ov_pre", s_out_valid, 1);
    chk("sim_head_pre", s_out_time, 30);
    s_in_time = 33'd32; s_out_ready = 1;
    step();
    s_in_valid = 0;
    chk("sim_count", s_count, 2);
    chk("sim_head", s_out_time, 31);
    step();
    chk("sim_head_new", s_out_time, 32);
    step();
    chk("sim_empty", s_count, 0);
    s_out_ready = 0;

    // Order error stays sticky and both entries still issue in arrival order
    s_in_valid = 1; s_in_time = 33'd40;
    step();
    chk("oe_clear", s_order_err, 0);
    chk("oe_cur", s_cur_time, 40);
    s_in_time = 33'd35;
    step();
    s_in_valid = 0;
    chk("oe_set", s_order_err, 1);
    chk("oe_count", s_count, 2);
    chk("oe_head_first", s_out_time, 40);
    s_out_ready = 1;
    step();
    chk("oe_head_second", s_out_time, 35);
    chk("oe_sticky_a", s_order_err, 1);
    step();
    chk("oe_drained", s_count, 0);
    chk("oe_sticky_b", s_order_err, 1);
    s_out_ready = 0;

    // Asynchronous reset mid-operation
    s_in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      s_in_time = 33'(50 + i);
      step();
    end
    s_in_valid = 0;
    chk("mid_count_pre", s_count, 3);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_count", s_count, 0);
    chk("mid_out_valid", s_out_valid, 0);
    chk("mid_cur", s_cur_time, 0);
    chk("mid_order_err", s_order_err, 0);
    chk("mid_state", s_state, 0);
    chk("mid_in_ready", s_in_ready, 1);
    chk("mid_cur_n", n_cur_time, 0);
    #2;
    rst = 1'b0;
    step();
    chk("post_rst_cur", s_cur_time, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_request_queue.md
TRACE_REQUEST_QUEUE -- requirements
Module: trace_request_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16: queue entries, power of 2, at least 2.
REQ-002 The block SHALL have parameter TIME_W, default 33: width of request time and simulation time.
REQ-003 The block SHALL have parameter OP_W, default 2: width of the operation code.
REQ-004 The block SHALL have parameter ADDR_W, default 33: width of the request address.
REQ-005 The block SHALL have parameter SKIP_EN, default 1: enables the idle time-skip rule in REQ-022.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset, with ports listed in REQ-007 to REQ-021.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 in_valid  input  1  parsed trace entry present.
REQ-010 in_ready  output  1  queue can accept an entry.
REQ-011 in_time  input  TIME_W  cycle at which the request is issued.
REQ-012 in_op  input  OP_W  operation code.
REQ-013 in_addr  input  ADDR_W  request address.
REQ-014 out_valid  output  1  head entry is due for issue.
REQ-015 out_ready  input  1  consumer accepts the head entry.
REQ-016 out_time, out_op, out_addr  output  TIME_W/OP_W/ADDR_W  head entry fields.
REQ-017 cur_time  output  TIME_W  simulation time counter.
REQ-018 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-019 full, empty  output  1 each  status flags, with full = (count==DEPTH) and empty = (count==0).
REQ-020 state  output  2  status code: 0 IDLE, 1 WAIT, 2 ISSUE.
REQ-021 order_err  output  1  sticky error flag for a time-order violation.

Function
REQ-022 cur_time SHALL increment by 1 every cycle, saturating at all-ones.
- Exception: SKIP_EN=1, empty=1, an enqueue occurs this cycle, and in_time > cur_time+1.
- In that case cur_time SHALL load in_time.
REQ-023 in_ready SHALL equal !full; an enqueue occurs on any edge where in_valid && in_ready.
REQ-024 Entries SHALL be stored in a circular buffer and read in FIFO order.
- Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 out_valid SHALL equal !empty && (head time <= cur_time), decoded from registers with no input-to-output path.
REQ-026 out_time, out_op and out_addr SHALL present the head entry whenever empty=0, independent of out_valid.
REQ-027 A dequeue SHALL occur on any edge where out_valid && out_ready; the read pointer advances by 1.
REQ-028 Latency: an entry written at edge N SHALL be visible at the head no earlier than the cycle after edge N; there is no input-to-output bypass.
REQ-029 Simultaneous enqueue and dequeue SHALL leave count unchanged and update both pointers.
REQ-030 When full=1, an enqueue SHALL NOT occur even if a dequeue occurs in the same cycle.
REQ-031 When empty=1, out_valid SHALL be 0 and out_ready SHALL be ignored.
REQ-032 order_err SHALL set on an accepted entry whose in_time is less than the last accepted in_time.
- The entry SHALL still be enqueued.
- order_err SHALL clear only on reset.
REQ-033 The last accepted time register SHALL update on every enqueue.
REQ-034 state SHALL be decoded from registered contents:
- IDLE when empty=1.
- WAIT when empty=0 and out_valid=0.
- ISSUE when out_valid=1.
REQ-035 Legal transitions per edge: IDLE->WAIT, IDLE->ISSUE, WAIT->ISSUE, ISSUE->WAIT, ISSUE->IDLE, WAIT->IDLE (reset only), and hold.
REQ-036 Equal in_time values SHALL issue in arrival order, one per accepted dequeue.

Reset
REQ-037 While rst=1, the block SHALL asynchronously force:
- pointers, count, cur_time, last accepted time and order_err to 0;
- empty=1, full=0, in_ready=1, out_valid=0, state=IDLE.
REQ-038 Assertion of rst mid-operation SHALL discard all stored entries immediately, without waiting for a clock edge.
REQ-039 Storage array contents SHALL NOT require reset; head fields are don't-care while empty=1.
REQ-040 The first edge after rst deasserts SHALL behave as a normal cycle with cur_time 0->1.

Verification
REQ-041 Run all scenarios with DEPTH=4 and SKIP_EN=1 unless stated otherwise.
REQ-042 Skip: reset; enqueue (time 50, op 1, addr 0x1A0) while empty.
- Next cycle: cur_time=50, out_valid=1, state=ISSUE, out_addr=0x1A0.
REQ-043 Gating, SKIP_EN=0: enqueue (time 5) at cur_time 1.
- out_valid=0 and state=WAIT through cur_time 4.
- out_valid=1 at cur_time 5; with out_ready=1, count returns to 0 next cycle.
REQ-044 Full/wrap: enqueue 4 entries with times 10, 11, 12, 13 while out_ready=0.
- full=1 and in_ready=0; a 5th in_valid is not accepted.
- Then drain 6 entries across wrap: issue order is correct and pointers wrap to 0 and beyond.
REQ-045 Simultaneous: count=2, head due; assert in_valid and out_ready together.
- count stays 2; the new entry becomes 2nd after the old 2nd entry.
REQ-046 Order error: accept time 20, then time 15.
- order_err=1 the next cycle and remains 1; both entries issue in arrival order.
REQ-047 Reset mid-operation: count=3; assert rst between clock edges.
- count=0, out_valid=0 and cur_time=0 immediately, before the next edge.
